// File: rtl/des_decrypt_iter.sv
// Iterative single-DES decryption core, one Feistel round per clock (K16 first).
// Latency: accept edge T -> out_valid visible in cycle T+16; at most one block per 18 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, stalls indefinitely.
module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipherText,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plainText,
  output logic        busy
);

  // Tables list source bit positions, DES numbering (bit 1 = MSB of the vector).
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
  };

  // Parity bits (8,16,...,64) never appear here, so they are dropped.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  // Each S-box is 64 nibbles, row-major (row*16+col), entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], x[6'(64 - IP_T[i])]};
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], x[6'(64 - FP_T[i])]};
    return o;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[46:0], x[5'(32 - E_T[i])]};
    return o;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o = {o[30:0], x[5'(32 - P_T[i])]};
    return o;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o = {o[54:0], x[6'(64 - PC1_T[i])]};
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[46:0], x[6'(56 - PC2_T[i])]};
    return o;
  endfunction

  // Six input bits b1..b6 per box: row = {b1,b6}, column = b2..b5.
  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0]  o;
    logic [5:0]   six;
    logic [5:0]   idx;
    logic [255:0] tmp;
    o = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(x >> (42 - 6 * b));
      idx = {six[5], six[0], six[4:1]};
      tmp = SBOX[b] >> (4 * (63 - int'(idx)));
      o   = {o[27:0], tmp[3:0]};
    end
    return o;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  rnd;
  logic [31:0] l;
  logic [31:0] r;
  logic [27:0] c;
  logic [27:0] d;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [31:0] l_nxt;
  logic [31:0] r_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, 16 rounds, hold DONE until the consumer takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = ROUND;
      ROUND:   if (rnd == 4'd15)  state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Key schedule in reverse: right rotations walk C/D from C16/D16 back to C1/D1.
  always_comb begin
    c_rot = c;
    d_rot = d;
    if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) begin
      c_rot = {c[0], c[27:1]};
      d_rot = {d[0], d[27:1]};
    end else if (rnd != 4'd0) begin
      c_rot = {c[1:0], c[27:2]};
      d_rot = {d[1:0], d[27:2]};
    end
  end

  assign subkey = perm_pc2({c_rot, d_rot});
  assign f_out  = perm_p(sbox_sub(perm_e(r) ^ subkey));
  assign l_nxt  = r;
  assign r_nxt  = l ^ f_out;

  // Datapath: load on accept, one round per ROUND cycle, capture result on the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      rnd       <= '0;
      plainText <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            {l, r} <= perm_ip(cipherText);
            {c, d} <= perm_pc1(key);
            rnd    <= '0;
          end
        end
        ROUND: begin
          l <= l_nxt;
          r <= r_nxt;
          c <= c_rot;
          d <= d_rot;
          if (rnd == 4'd15) plainText <= perm_fp({r_nxt, l_nxt});
          else              rnd       <= rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: known-answer vectors, parity, backpressure, input churn, reset.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Every wait for the DUT is bounded by a cycle budget.
module tb_des_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] cipherText;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plainText;
  logic        busy;

  int checks  = 0;
  int errors  = 0;
  int both_hi = 0;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;
  localparam logic [63:0] K3  = 64'h0101010101010101;
  localparam logic [63:0] C3  = 64'h95F8A5E5DD31D900;
  localparam logic [63:0] P3  = 64'h8000000000000000;
  localparam logic [63:0] K1P = 64'h123556789ABDDEF0;

  des_decrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cipherText (cipherText),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plainText  (plainText),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // in_ready and out_valid must never be high together.
  always @(negedge clk) if (in_ready && out_valid) both_hi++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for out_valid, returning the number of edges taken (bounded).
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [63:0] k, input logic [63:0] ct,
                         input logic [63:0] pt, input bit scramble);
    int n;
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    key = k; cipherText = ct; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        key        = {$urandom, $urandom};
        cipherText = {$urandom, $urandom};
        in_valid   = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd16);
    chk({tag, " plain"}, plainText, pt);
    @(posedge clk); #1;
    chk({tag, " done_1cyc"}, 64'(out_valid), 64'd0);
    chk({tag, " idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " plain_kept"}, plainText, pt);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0; cipherText = '0;
    #3;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst plain", plainText, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("v1", K1, C1, P1, 1'b0);
    run_vec("v2", K2, C2, P2, 1'b0);
    run_vec("v3", K3, C3, P3, 1'b0);
    run_vec("parity", K1P, C1, P1, 1'b0);
    run_vec("churn", K1, C1, P1, 1'b1);

    // Backpressure: vector 2 with out_ready low, vector 1 waiting on in_valid.
    key = K2; cipherText = C2; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    key = K1; cipherText = C1;
    wait_out(n);
    chk("bp latency", 64'(n), 64'd16);
    for (int i = 0; i < 10; i++) begin
      chk("bp plain", plainText, P2);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("bp still_done", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp idle", 64'(in_ready), 64'd1);
    chk("bp valid_low", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("bp reaccept", 64'(busy), 64'd1);
    in_valid = 1'b0;
    wait_out(n);
    chk("bp2 latency", 64'(n), 64'd16);
    chk("bp2 plain", plainText, P1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of round 7.
    key = K1; cipherText = C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst plain", plainText, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst plain", plainText, 64'h0);
    run_vec("post_rst", K1, C1, P1, 1'b0);

    chk("ready_valid_excl", 64'(both_hi), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
